// File: rtl/lc3b_types.sv
// Shared L2 data-array types and default configuration constants.
package lc3b_types;

  localparam int unsigned L2_WIDTH = 128;
  localparam int unsigned L2_SETS  = 8;
  localparam int unsigned L2_WAYS  = 2;

  localparam int unsigned L2_IDX_W = $clog2(L2_SETS);
  localparam int unsigned L2_WAY_W = (L2_WAYS > 1) ? $clog2(L2_WAYS) : 1;
  localparam int unsigned L2_BE_W  = L2_WIDTH / 8;

  typedef logic [L2_IDX_W-1:0] l2_idx_t;
  typedef logic [L2_WAY_W-1:0] l2_way_t;
  typedef logic [L2_BE_W-1:0]  l2_be_t;

endpackage

// File: rtl/l2_data_way.sv
// One way of the L2 data store: SETS lines with a byte-masked write port and an asynchronous read port.
module l2_data_way
  import lc3b_types::*;
#(
  parameter int unsigned WIDTH = L2_WIDTH,
  parameter int unsigned SETS  = L2_SETS
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(SETS)-1:0]    index,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [WIDTH/8-1:0]         be,
  input  logic [$clog2(SETS)-1:0]    rd_index,
  output logic [WIDTH-1:0]           rd_line
);

  localparam int unsigned BE_W = WIDTH / 8;

  logic [WIDTH-1:0] mem [SETS];

  // Storage is cleared by the owner's init sweep, so no reset here.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (be[b]) mem[index][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rd_line = mem[rd_index];

endmodule

// File: rtl/l2_data_array.sv
// L2 data array: init sweep FSM, fill/write arbitration onto a single write port, registered read with write-first bypass.
module l2_data_array
  import lc3b_types::*;
#(
  parameter int unsigned WIDTH = L2_WIDTH,
  parameter int unsigned SETS  = L2_SETS,
  parameter int unsigned WAYS  = L2_WAYS
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  output logic                                          ready,
  input  logic                                          fill_valid,
  input  logic [$clog2(SETS)-1:0]                       fill_index,
  input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]    fill_way,
  input  logic [WIDTH-1:0]                              fill_data,
  input  logic                                          wr_valid,
  output logic                                          wr_ready,
  input  logic [$clog2(SETS)-1:0]                       wr_index,
  input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]    wr_way,
  input  logic [WIDTH-1:0]                              wr_data,
  input  logic [WIDTH/8-1:0]                            wr_be,
  input  logic                                          rd_valid,
  input  logic [$clog2(SETS)-1:0]                       rd_index,
  input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]    rd_way,
  output logic [WIDTH-1:0]                              rdata,
  output logic                                          rdata_valid
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned BE_W  = WIDTH / 8;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] sweep_cnt_q, sweep_cnt_d;

  logic             fill_go, wr_go, rd_go;
  logic [WIDTH-1:0] way_line [WAYS];
  logic [WIDTH-1:0] rd_line_c, wr_merge_c, rd_next_c;
  logic             rd_hit_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  // Sweep one set per cycle; the last set written hands over to RUN.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    if (state_q == ST_INIT) begin
      sweep_cnt_d = sweep_cnt_q + IDX_W'(1);
      if (sweep_cnt_q == IDX_W'(SETS - 1)) state_d = ST_RUN;
    end
  end

  assign ready    = (state_q == ST_RUN);
  assign fill_go  = ready & fill_valid;
  assign wr_go    = ready & wr_valid & ~fill_valid;
  assign wr_ready = ready & ~fill_valid;
  assign rd_go    = ready & rd_valid;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic             we;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] wdata;
    logic [BE_W-1:0]  be;

    // Fill has priority on the shared write port; the sweep owns it during init.
    always_comb begin
      we    = 1'b0;
      idx   = '0;
      wdata = '0;
      be    = '0;
      if (!ready) begin
        we  = 1'b1;
        idx = sweep_cnt_q;
        be  = '1;
      end else if (fill_go && fill_way == WAY_W'(w)) begin
        we    = 1'b1;
        idx   = fill_index;
        wdata = fill_data;
        be    = '1;
      end else if (wr_go && wr_way == WAY_W'(w)) begin
        we    = 1'b1;
        idx   = wr_index;
        wdata = wr_data;
        be    = wr_be;
      end
    end

    l2_data_way #(
      .WIDTH (WIDTH),
      .SETS  (SETS)
    ) u_way (
      .clk      (clk),
      .we       (we),
      .index    (idx),
      .wdata    (wdata),
      .be       (be),
      .rd_index (rd_index),
      .rd_line  (way_line[w])
    );
  end

  // Read mux with write-first bypass; an unpopulated way reads as zero.
  always_comb begin
    rd_line_c = '0;
    rd_hit_c  = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (rd_way == WAY_W'(w)) begin
        rd_line_c = way_line[w];
        rd_hit_c  = 1'b1;
      end
    end
    wr_merge_c = rd_line_c;
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (wr_be[b]) wr_merge_c[8*b +: 8] = wr_data[8*b +: 8];
    end
    rd_next_c = rd_line_c;
    if (rd_hit_c) begin
      if (fill_go && fill_index == rd_index && fill_way == rd_way) begin
        rd_next_c = fill_data;
      end else if (wr_go && wr_index == rd_index && wr_way == rd_way) begin
        rd_next_c = wr_merge_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= rd_go;
      if (rd_go) rdata <= rd_next_c;
    end
  end

endmodule
